// File: rtl/jtdsp16_pram_if.sv
// Bus bundle for jtdsp16_pram: instruction-fetch read port plus byte-wide download stream.
interface jtdsp16_pram_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          cen;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          prog_start;
  logic [AW-1:0] prog_base;
  logic [AW-1:0] prog_len;
  logic [7:0]    prog_data;
  logic          prog_we;
  logic          busy;
  logic          done;
  logic          werr;

  modport master (
    output cen, addr, prog_start, prog_base, prog_len, prog_data, prog_we,
    input  dout, busy, done, werr
  );

  modport slave (
    input  cen, addr, prog_start, prog_base, prog_len, prog_data, prog_we,
    output dout, busy, done, werr
  );
endinterface

// File: rtl/jtdsp16_pram.sv
// DSP16 program RAM: byte-stream loader assembling little-endian words, and a
// registered write-first read port for instruction fetch.
module jtdsp16_pram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  jtdsp16_pram_if.slave   bus
);
  localparam int BPW = DW / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST = BW'(BPW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  state_t        state_r;
  logic [AW-1:0] wptr_r;
  logic [AW:0]   left_r;
  logic [BW-1:0] bidx_r;
  logic [DW-1:0] asm_r;
  logic [DW-1:0] dout_r;
  logic          busy_r;
  logic          done_r;
  logic          werr_r;

  logic [DW-1:0] word_s;
  logic          wr_s;

  // Full word: earlier lanes from the assembly register, top lane straight from the bus
  always_comb begin
    word_s = asm_r;
    // top lane of asm_r is never written, so the OR just passes the incoming byte
    word_s[DW-1 -: 8] = asm_r[DW-1 -: 8] | bus.prog_data;
  end

  // Word write strobe: last byte of a word accepted in LOAD, not pre-empted by start or reset
  always_comb begin
    if (!rst && !bus.prog_start && bus.prog_we && (state_r == LOAD) && (bidx_r == LAST)) begin
      wr_s = 1'b1;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem[wptr_r] <= word_s;
    end
  end

  // Registered read port with write-first bypass on address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {DW{1'b0}};
    end else if (bus.cen) begin
      if (wr_s && (bus.addr == wptr_r)) begin
        dout_r <= word_s;
      end else begin
        dout_r <= mem[bus.addr];
      end
    end
  end

  // Load session controller
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      wptr_r  <= {AW{1'b0}};
      left_r  <= {(AW+1){1'b0}};
      bidx_r  <= {BW{1'b0}};
      asm_r   <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      werr_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.prog_start) begin
        state_r <= LOAD;
        busy_r  <= 1'b1;
        wptr_r  <= bus.prog_base;
        // zero length stands for the whole array
        left_r  <= (bus.prog_len == {AW{1'b0}}) ? {1'b1, {AW{1'b0}}} : {1'b0, bus.prog_len};
        bidx_r  <= {BW{1'b0}};
        asm_r   <= {DW{1'b0}};
        werr_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.prog_we) begin
              werr_r <= 1'b1;
            end
          end
          LOAD: begin
            if (bus.prog_we) begin
              if (bidx_r == LAST) begin
                wptr_r <= wptr_r + AW'(1);
                left_r <= left_r - (AW+1)'(1);
                bidx_r <= {BW{1'b0}};
                asm_r  <= {DW{1'b0}};
                if (left_r == (AW+1)'(1)) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                end
              end else begin
                asm_r[{bidx_r, 3'b000} +: 8] <= bus.prog_data;
                bidx_r <= bidx_r + BW'(1);
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout = dout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.werr = werr_r;
endmodule

// File: tb/tb_jtdsp16_pram.sv
// Randomised self-checking bench for jtdsp16_pram: a 4096x16 instance checked every
// cycle against a byte-queue session model, and a 256x24 instance doing a full-array load.
module tb_jtdsp16_pram;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtdsp16_pram_if #(.AW(12), .DW(16)) a_if ();
  jtdsp16_pram_if #(.AW(8),  .DW(24)) b_if ();

  jtdsp16_pram #(.AW(12), .DW(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  jtdsp16_pram #(.AW(8),  .DW(24)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the 16-bit instance
  logic [15:0] ref_a [4096];
  bit          val_a [4096];
  bit          m_busy, m_werr, m_done, dk;
  int          m_ptr, m_left;
  logic [7:0]  pend[$];
  logic [15:0] dv;

  task automatic cyc_a(input bit r, input bit st, input int base, input int len,
                       input bit we, input logic [7:0] d, input bit c, input int ad);
    rst             = r;
    a_if.prog_start = st;
    a_if.prog_base  = 12'(base);
    a_if.prog_len   = 12'(len);
    a_if.prog_we    = we;
    a_if.prog_data  = d;
    a_if.cen        = c;
    a_if.addr       = 12'(ad);
    m_done = 1'b0;
    if (r) begin
      m_busy = 1'b0;
      m_werr = 1'b0;
      pend.delete();
      dk = 1'b1;
      dv = 16'h0000;
    end else begin
      if (st) begin
        m_busy = 1'b1;
        m_werr = 1'b0;
        m_ptr  = base % 4096;
        m_left = (len % 4096 == 0) ? 4096 : len % 4096;
        pend.delete();
      end else if (we) begin
        if (!m_busy) m_werr = 1'b1;
        else begin
          pend.push_back(d);
          if (pend.size() == 2) begin
            ref_a[m_ptr] = {pend[1], pend[0]};
            val_a[m_ptr] = 1'b1;
            m_ptr  = (m_ptr + 1) % 4096;
            m_left = m_left - 1;
            pend.delete();
            if (m_left == 0) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
      if (c) begin
        dk = val_a[ad % 4096];
        dv = ref_a[ad % 4096];
      end
    end
    @(posedge clk);
    #1;
    check_eq("busy", a_if.busy, m_busy);
    check_eq("done", a_if.done, m_done);
    check_eq("werr", a_if.werr, m_werr);
    if (dk) check_eq("dout", a_if.dout, dv);
  endtask

  task automatic byte_a(input logic [7:0] d);
    cyc_a(1'b0, 1'b0, 0, 0, 1'b1, d, 1'b0, 0);
  endtask

  task automatic read_a(input int ad);
    cyc_a(1'b0, 1'b0, 0, 0, 1'b0, 8'h00, 1'b1, ad);
  endtask

  logic [23:0] ref_b [256];
  logic [23:0] w;

  initial begin : main
    int base, len, k, sel, ad, nd, bbase;
    bit we, c;
    for (int i = 0; i < 4096; i++) val_a[i] = 1'b0;
    b_if.prog_start = 1'b0; b_if.prog_base = 8'h00; b_if.prog_len = 8'h00;
    b_if.prog_we = 1'b0; b_if.prog_data = 8'h00; b_if.cen = 1'b0; b_if.addr = 8'h00;

    // Reset, then a stray byte while idle
    cyc_a(1'b1, 1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 0);
    cyc_a(1'b1, 1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 0);
    check_eq("b_rst_dout", b_if.dout, 24'h0);
    byte_a(8'hAA);
    check_eq("idle_werr", a_if.werr, 1'b1);
    read_a(0);

    // Basic load
    cyc_a(1'b0, 1'b1, 'h010, 2, 1'b0, 8'h00, 1'b0, 0);
    byte_a(8'h34); byte_a(8'h12); byte_a(8'h78); byte_a(8'h56);
    check_eq("basic_done", a_if.done, 1'b1);
    read_a('h011);
    check_eq("rd_011", a_if.dout, 16'h5678);
    read_a('h010);
    check_eq("rd_010", a_if.dout, 16'h1234);
    check_eq("basic_busy", a_if.busy, 1'b0);

    // Wrap-around
    cyc_a(1'b0, 1'b1, 'hFFF, 2, 1'b0, 8'h00, 1'b0, 0);
    byte_a(8'h01); byte_a(8'h00); byte_a(8'h02); byte_a(8'h00);
    read_a('hFFF);
    check_eq("rd_fff", a_if.dout, 16'h0001);
    read_a('h000);
    check_eq("rd_000", a_if.dout, 16'h0002);

    // Restart with colliding byte, then write-first read
    cyc_a(1'b0, 1'b1, 'h040, 3, 1'b0, 8'h00, 1'b0, 0);
    byte_a(8'h11);
    cyc_a(1'b0, 1'b1, 'h020, 1, 1'b1, 8'h99, 1'b0, 0);
    byte_a(8'hEF);
    cyc_a(1'b0, 1'b0, 0, 0, 1'b1, 8'hBE, 1'b1, 'h020);
    check_eq("wf_beef", a_if.dout, 16'hBEEF);
    read_a('h020);
    check_eq("rd_020", a_if.dout, 16'hBEEF);

    // Reset mid-load
    cyc_a(1'b0, 1'b1, 'h103, 1, 1'b0, 8'h00, 1'b0, 0);
    byte_a(8'hCD); byte_a(8'hAB);
    cyc_a(1'b0, 1'b1, 'h100, 4, 1'b0, 8'h00, 1'b0, 0);
    for (int i = 0; i < 7; i++) byte_a(8'($urandom));
    cyc_a(1'b1, 1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 0);
    check_eq("rst_busy", a_if.busy, 1'b0);
    byte_a(8'h77);
    for (int i = 0; i < 4; i++) read_a('h100 + i);
    check_eq("rd_103", a_if.dout, 16'hABCD);

    // Randomised sessions with gaps, restarts, stray bytes and concurrent reads
    for (int s = 0; s < 25; s++) begin
      base = $urandom % 4096;
      len  = 1 + $urandom % 6;
      k = 0;
      cyc_a(1'b0, 1'b1, base, len, 1'b0, 8'h00, 1'b0, 0);
      while (m_busy && k < 200) begin
        we  = ($urandom % 10) < 7;
        c   = $urandom % 2;
        sel = $urandom % 3;
        ad  = (sel == 0) ? m_ptr : (sel == 1) ? (m_ptr + 4095) % 4096 : $urandom % 4096;
        if ($urandom % 60 == 0)
          cyc_a(1'b0, 1'b1, $urandom % 4096, 1 + $urandom % 4, we, 8'($urandom), c, ad);
        else
          cyc_a(1'b0, 1'b0, 0, 0, we, 8'($urandom), c, ad);
        k++;
      end
      if ($urandom % 3 == 0) byte_a(8'h5A);
    end
    for (int i = 0; i < 4096; i++) if (val_a[i]) read_a(i);

    // Full-array load on the 24-bit instance
    bbase = $urandom % 256;
    w = 24'($urandom);
    for (int i = 0; i < 256; i++) ref_b[(bbase + i) % 256] = w + 24'(i);
    nd = 0;
    b_if.prog_start = 1'b1; b_if.prog_base = 8'(bbase); b_if.prog_len = 8'h00;
    @(posedge clk); #1;
    b_if.prog_start = 1'b0;
    check_eq("b_busy_rise", b_if.busy, 1'b1);
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 3; j++) begin
        while ($urandom % 4 == 0) begin
          b_if.prog_we = 1'b0;
          @(posedge clk); #1;
          if (b_if.done) nd++;
        end
        b_if.prog_we = 1'b1;
        b_if.prog_data = ref_b[(bbase + i) % 256][8*j +: 8];
        @(posedge clk); #1;
        if (b_if.done) nd++;
      end
      if (i == 128) check_eq("b_busy_mid", b_if.busy, 1'b1);
    end
    b_if.prog_we = 1'b0;
    check_eq("b_done_last", b_if.done, 1'b1);
    check_eq("b_busy_end", b_if.busy, 1'b0);
    @(posedge clk); #1;
    if (b_if.done) nd++;
    check_eq("b_done_cnt", nd, 1);
    for (int i = 0; i < 256; i++) begin
      b_if.cen = 1'b1; b_if.addr = 8'(i);
      @(posedge clk); #1;
      check_eq("b_rd", b_if.dout, ref_b[i]);
    end
    b_if.cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_if.addr = 8'($urandom);
      @(posedge clk); #1;
      check_eq("b_hold", b_if.dout, ref_b[255]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtdsp16_pram.md
# jtdsp16_pram

Clocked, parametrised program RAM for the DSP16 core, replacing the fixed 4096×16 combinational ROM. It adds a byte-wide streaming loader that assembles bytes into DW-bit words and writes them at an auto-incrementing address from a programmable base over a programmable length. It also adds a registered read port for the instruction fetch stage. It sits between the external download bus (host/SDRAM loader) and the DSP16 program counter.

## Interface
- AW, 12, address width; depth = 2^AW words
- DW, 16, word width; must be a multiple of 8; BPW = DW/8 bytes per word
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- cen  input  1  read-port clock enable
- addr  input  AW  read address (program counter)
- dout  output  DW  registered read data
- prog_start  input  1  one-cycle pulse; begin a load session
- prog_base  input  AW  first word address of the session, sampled on prog_start
- prog_len  input  AW  word count, sampled on prog_start; 0 means 2^AW words
- prog_data  input  8  download byte
- prog_we  input  1  byte strobe; one byte accepted per cycle while busy
- busy  output  1  high while a session is active
- done  output  1  one-cycle pulse after the last word of a session is written
- werr  output  1  sticky; a byte arrived while idle; cleared by rst or prog_start

## Operation
- Storage: 2^AW × DW array, not reset. Contents are undefined until loaded.
- States: IDLE, LOAD.
- IDLE → LOAD on prog_start:
  - wptr ← prog_base, remaining ← prog_len (0 maps to 2^AW).
  - Byte index bidx ← 0, assembly register cleared, werr ← 0.
- LOAD behaviour:
  - Each prog_we stores prog_data into byte lane bidx of the assembly register. Byte order is little-endian: the first byte is bits 7:0.
  - bidx then increments.
  - On the byte with bidx = BPW−1, the full word (lanes 0..BPW−2 from the register, lane BPW−1 from prog_data) is written to mem[wptr] in that same cycle.
  - After that write: wptr increments modulo 2^AW (wraps from 2^AW−1 to 0), remaining decrements, and bidx returns to 0.
- Session end: when a write brings remaining to 0, the next state is IDLE and done pulses high in the following cycle.
- prog_start during LOAD restarts the session: new base and length are taken, and any partial word is discarded.
- prog_start and prog_we in the same cycle: start wins and the byte is dropped.
- prog_we in IDLE: the byte is ignored and werr is set.
- Read port:
  - When cen = 1: dout ← mem[addr].
  - When cen = 0: dout holds.
  - Reads are permitted during LOAD.
  - If the read and write addresses match in the same cycle, the read is write-first: dout receives the new word.
- Reset values: dout = 0, busy = 0, done = 0, werr = 0, state = IDLE, bidx = 0, wptr = 0, remaining = 0.
- rst during LOAD aborts the session: no further writes occur, any partial word is lost, and words already written stay in memory.

## Timing
- Read latency is 1 cycle: addr presented at edge n with cen = 1 appears on dout after edge n+1.
- busy rises in the cycle after prog_start. It falls in the cycle after the final word write, which is the same cycle that done is high.
- Write latency: a word is written on the edge that accepts its last byte. A read of that address issued in that cycle returns the new data (write-first). A read issued one cycle later also returns the new data.
- Throughput: 1 byte/cycle sustained, giving 1 word every BPW cycles. Gaps in prog_we are allowed at any point.
- done is exactly one cycle wide and never overlaps a busy = 1 cycle of the same session.
- Minimum session duration: BPW cycles from the first byte to the final write, for prog_len = 1.

## Test plan
- Reset then idle: assert rst for 2 cycles → dout = 0, busy = 0, done = 0, werr = 0. Send prog_we with 0xAA while idle → werr = 1 and memory unchanged.
- Basic load (DW = 16):
  - Stimulus: prog_start with base 0x010, len 2; then bytes 0x34, 0x12, 0x78, 0x56 on consecutive cycles.
  - Required: mem[0x010] = 0x1234, mem[0x011] = 0x5678; done pulses once, 1 cycle after the 4th byte; busy is low afterwards.
  - Read-back: reading addr 0x011 with cen = 1 gives dout = 0x5678 one cycle later.
- Wrap-around: base 0xFFF, len 2, bytes 01 00 02 00 → mem[0xFFF] = 0x0001 and mem[0x000] = 0x0002.
- Restart and collision:
  - Send 1 byte, then prog_start together with a prog_we byte, using base 0x020 and len 1.
  - Then send bytes EF BE while addr = 0x020 and cen = 1 on the second byte.
  - Required: mem[0x020] = 0xBEEF, and dout = 0xBEEF on the next cycle (write-first); no write from the aborted partial word.
- Reset mid-load: with len 4, after 3 full words plus 1 byte, assert rst → the 3 words are intact, busy = 0, no done pulse, and the 4th address is unmodified.
- Parametrised instance AW = 8, DW = 24:
  - Stimulus: len 0, then 768 bytes forming an incrementing word pattern.
  - Required: all 256 words are correct, done pulses once, and dout holds its value while cen = 0.
